// File: rtl/hdmi_decoder_pkg.sv
// Shared types and symbol constants for the TMDS/HDMI receive decoder.
// Holds the period enum, control/guard/TERC4 codes and the TERC4 lookup.
package hdmi_decoder_pkg;

    typedef enum logic [2:0] {
        CTRL      = 3'd0,
        PRE_V     = 3'd1,
        PRE_D     = 3'd2,
        VGB       = 3'd3,
        VIDEO     = 3'd4,
        DGB_LEAD  = 3'd5,
        DATA      = 3'd6,
        DGB_TRAIL = 3'd7
    } period_t;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [9:0] VGB_CH02 = 10'b1011001100;
    localparam logic [9:0] GB_CH12  = 10'b0100110011;

    localparam logic [3:0] CTL_PRE_V = 4'b0001;
    localparam logic [3:0] CTL_PRE_D = 4'b0101;
    localparam logic [3:0] PRE_MIN   = 4'd8;

    // Returns {valid, nibble}; valid is low for any non-TERC4 symbol.
    function automatic logic [4:0] terc4_decode(input logic [9:0] q);
        case (q)
            10'b1010011100: terc4_decode = 5'h10;
            10'b1001100011: terc4_decode = 5'h11;
            10'b1011100100: terc4_decode = 5'h12;
            10'b1011100010: terc4_decode = 5'h13;
            10'b0101110001: terc4_decode = 5'h14;
            10'b0100011110: terc4_decode = 5'h15;
            10'b0110001110: terc4_decode = 5'h16;
            10'b0100111100: terc4_decode = 5'h17;
            10'b1011001100: terc4_decode = 5'h18;
            10'b0100111001: terc4_decode = 5'h19;
            10'b0110011100: terc4_decode = 5'h1A;
            10'b1011000110: terc4_decode = 5'h1B;
            10'b1010001110: terc4_decode = 5'h1C;
            10'b1001110001: terc4_decode = 5'h1D;
            10'b0101100011: terc4_decode = 5'h1E;
            10'b1011000011: terc4_decode = 5'h1F;
            default:        terc4_decode = 5'h00;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_decoder_symbol.sv
// Combinational per-channel classifier: video data, control token, TERC4 and
// guard-band recognition for one aligned 10-bit TMDS symbol.
module tmds_symbol_decode
    import hdmi_decoder_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic [9:0] q,
    output logic [7:0] data8,
    output logic       is_ctrl,
    output logic [1:0] ctrl2,
    output logic       is_terc4,
    output logic [3:0] terc4,
    output logic       is_vgb,
    output logic       is_dgb
);

    logic [7:0] d_s;
    logic [4:0] terc4_s;

    // Video: undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        d_s      = q[9] ? ~q[7:0] : q[7:0];
        data8    = 8'd0;
        data8[0] = d_s[0];
        for (int i = 1; i < 8; i++) begin
            data8[i] = q[8] ? (d_s[i] ^ d_s[i-1]) : ~(d_s[i] ^ d_s[i-1]);
        end
    end

    // Control token recognition
    always_comb begin
        is_ctrl = 1'b1;
        ctrl2   = 2'b00;
        case (q)
            CTRL_TOKEN_00: ctrl2 = 2'b00;
            CTRL_TOKEN_01: ctrl2 = 2'b01;
            CTRL_TOKEN_10: ctrl2 = 2'b10;
            CTRL_TOKEN_11: ctrl2 = 2'b11;
            default:       is_ctrl = 1'b0;
        endcase
    end

    assign terc4_s  = terc4_decode(q);
    assign is_terc4 = terc4_s[4];
    assign terc4    = terc4_s[3:0];
    assign is_vgb   = (CHANNEL == 32'sd1) ? (q == GB_CH12) : (q == VGB_CH02);
    // ch0 of a data-island guard is TERC4 {1,1,vsync,hsync}
    assign is_dgb   = (CHANNEL == 32'sd0) ? (terc4_s[4] && (terc4_s[3:2] == 2'b11))
                                          : (q == GB_CH12);

endmodule

// File: rtl/hdmi_decoder.sv
// Three-channel TMDS/HDMI receive decoder: period tracking FSM, pixel/TERC4
// recovery, raster position, lock and error status, all registered.
module hdmi_decoder
    import hdmi_decoder_pkg::*;
#(
    parameter int LOCK_TOKENS    = 16,
    parameter int UNLOCK_ERRORS  = 8,
    parameter int MAX_DI_PACKETS = 18
) (
    input  logic            clk_pixel,
    input  logic            reset,
    input  logic [2:0][9:0] tmds_i,
    output logic [23:0]     rgb_o,
    output logic            de_o,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic [3:0]      ctl_o,
    output logic [11:0]     terc4_o,
    output logic            di_valid_o,
    output logic            di_start_o,
    output logic            guard_o,
    output period_t         period_o,
    output logic [11:0]     x_o,
    output logic [11:0]     y_o,
    output logic            locked_o,
    output logic [15:0]     err_count_o
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_TOKENS);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_ERRORS);
    localparam logic [7:0] MAX_PKT  = 8'(MAX_DI_PACKETS);

    logic [2:0][7:0] data8_s;
    logic [2:0][1:0] ctrl2_s;
    logic [2:0][3:0] terc4_s;
    logic [2:0]      is_ctrl_s, is_terc4_s, is_vgb_s, is_dgb_s;

    for (genvar g = 0; g < 3; g++) begin : g_chan
        tmds_symbol_decode #(.CHANNEL(g)) u_dec (
            .q(tmds_i[g]), .data8(data8_s[g]), .is_ctrl(is_ctrl_s[g]), .ctrl2(ctrl2_s[g]),
            .is_terc4(is_terc4_s[g]), .terc4(terc4_s[g]), .is_vgb(is_vgb_s[g]), .is_dgb(is_dgb_s[g])
        );
    end

    logic       all_ctrl_s, all_terc4_s, all_dgb_s, gb_match_s;
    logic [3:0] ctl_in_s, entry_cnt_s;
    period_t    entry_s;

    assign all_ctrl_s  = &is_ctrl_s;
    assign all_terc4_s = &is_terc4_s;
    assign all_dgb_s   = &is_dgb_s;
    assign ctl_in_s    = {ctrl2_s[2], ctrl2_s[1]};
    assign entry_s     = (ctl_in_s == CTL_PRE_V) ? PRE_V : ((ctl_in_s == CTL_PRE_D) ? PRE_D : CTRL);
    assign entry_cnt_s = (entry_s == CTRL) ? 4'd0 : 4'd1;
    assign gb_match_s  = ((period_o == PRE_V) || (period_o == VGB)) ? (&is_vgb_s) : all_dgb_s;

    // state_r holds the period of the last registered symbol set
    period_t    state_r, state_s;
    logic [3:0] pre_cnt_r, pre_cnt_s;
    logic [1:0] gb_cnt_r, gb_cnt_s;
    logic [4:0] pkt_cyc_r, pkt_cyc_s;
    logic [7:0] pkt_num_r, pkt_num_s;
    logic       err_s;

    // State and period counters
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_r   <= CTRL;
            pre_cnt_r <= 4'd0;
            gb_cnt_r  <= 2'd0;
            pkt_cyc_r <= 5'd0;
            pkt_num_r <= 8'd0;
        end else begin
            state_r   <= state_s;
            pre_cnt_r <= pre_cnt_s;
            gb_cnt_r  <= gb_cnt_s;
            pkt_cyc_r <= pkt_cyc_s;
            pkt_num_r <= pkt_num_s;
        end
    end

    // Classify the incoming symbol set given the previous period
    always_comb begin
        state_s   = CTRL;
        pre_cnt_s = 4'd0;
        gb_cnt_s  = 2'd0;
        pkt_cyc_s = 5'd0;
        pkt_num_s = pkt_num_r;
        err_s     = 1'b0;
        case (state_r)
            CTRL, VIDEO: begin
                if (all_ctrl_s) begin
                    state_s   = entry_s;
                    pre_cnt_s = entry_cnt_s;
                end else if (state_r == VIDEO) begin
                    state_s = VIDEO;
                end else begin
                    err_s = 1'b1;
                end
            end
            PRE_V, PRE_D: begin
                if (all_ctrl_s && (entry_s == state_r)) begin
                    state_s   = state_r;
                    pre_cnt_s = (pre_cnt_r == 4'd15) ? 4'd15 : pre_cnt_r + 4'd1;
                end else if (all_ctrl_s) begin
                    state_s   = entry_s;
                    pre_cnt_s = entry_cnt_s;
                end else if (gb_match_s && (pre_cnt_r >= PRE_MIN)) begin
                    state_s  = (state_r == PRE_V) ? VGB : DGB_LEAD;
                    gb_cnt_s = 2'd1;
                end else begin
                    err_s = 1'b1;
                end
            end
            VGB, DGB_LEAD: begin
                if (gb_cnt_r == 2'd1) begin
                    state_s  = gb_match_s ? state_r : CTRL;
                    gb_cnt_s = 2'd2;
                    err_s    = !gb_match_s;
                end else if (gb_match_s) begin
                    err_s = 1'b1;
                end else if ((state_r == VGB) && all_ctrl_s) begin
                    state_s   = entry_s;
                    pre_cnt_s = entry_cnt_s;
                end else if (state_r == VGB) begin
                    state_s = VIDEO;
                end else if (all_terc4_s) begin
                    state_s   = DATA;
                    pkt_num_s = 8'd1;
                end else begin
                    err_s = 1'b1;
                end
            end
            DATA: begin
                if (all_dgb_s && (pkt_cyc_r == 5'd31)) begin
                    state_s  = DGB_TRAIL;
                    gb_cnt_s = 2'd1;
                end else if (!all_terc4_s || all_dgb_s) begin
                    err_s = 1'b1;
                end else if (pkt_cyc_r != 5'd31) begin
                    state_s   = DATA;
                    pkt_cyc_s = pkt_cyc_r + 5'd1;
                end else if (pkt_num_r >= MAX_PKT) begin
                    err_s = 1'b1;
                end else begin
                    state_s   = DATA;
                    pkt_num_s = pkt_num_r + 8'd1;
                end
            end
            DGB_TRAIL: begin
                if (gb_cnt_r == 2'd1) begin
                    state_s  = all_dgb_s ? DGB_TRAIL : CTRL;
                    gb_cnt_s = 2'd2;
                    err_s    = !all_dgb_s;
                end else if (all_ctrl_s) begin
                    state_s   = entry_s;
                    pre_cnt_s = entry_cnt_s;
                end else begin
                    err_s = 1'b1;
                end
            end
            default: err_s = 1'b1;
        endcase
    end

    logic        de_r, de_s, hsync_r, hsync_s, vsync_r, vsync_s;
    logic        di_valid_r, di_valid_s, di_start_r, di_start_s, guard_r, guard_s;
    logic [23:0] rgb_r, rgb_s;
    logic [11:0] terc4_r, terc4_out_s, x_r, x_s, y_r, y_s;
    logic [3:0]  ctl_r, ctl_s;
    logic        vs_pend_r, vs_pend_s, locked_r, locked_s;
    logic [7:0]  lock_cnt_r, lock_cnt_s, err_run_r, err_run_s, lock_inc_s, run_inc_s;
    logic [15:0] err_count_r, err_count_s;

    // Per-cycle outputs; sync and CTL hold through video
    always_comb begin
        de_s        = (state_s == VIDEO);
        di_valid_s  = (state_s == DATA);
        di_start_s  = di_valid_s && (pkt_cyc_s == 5'd0);
        guard_s     = (state_s == VGB) || (state_s == DGB_LEAD) || (state_s == DGB_TRAIL);
        rgb_s       = de_s ? {data8_s[2], data8_s[1], data8_s[0]} : 24'd0;
        terc4_out_s = di_valid_s ? {terc4_s[2], terc4_s[1], terc4_s[0]} : 12'd0;
        ctl_s       = all_ctrl_s ? ctl_in_s : ctl_r;
        if (all_ctrl_s) begin
            hsync_s = ctrl2_s[0][0];
            vsync_s = ctrl2_s[0][1];
        end else if (di_valid_s || (state_s == DGB_LEAD) || (state_s == DGB_TRAIL)) begin
            hsync_s = terc4_s[0][0];
            vsync_s = terc4_s[0][1];
        end else begin
            hsync_s = hsync_r;
            vsync_s = vsync_r;
        end
    end

    // Raster position, lock tracking and saturating error count
    always_comb begin
        vs_pend_s   = vs_pend_r || (vsync_s && !vsync_r);
        x_s         = x_r;
        y_s         = y_r;
        if (de_s && !de_r) begin
            x_s       = 12'd0;
            y_s       = vs_pend_s ? 12'd0 : y_r;
            vs_pend_s = 1'b0;
        end else if (de_s) begin
            x_s = x_r + 12'd1;
        end else if (de_r) begin
            y_s = y_r + 12'd1;
        end else begin
            x_s = x_r;
        end
        lock_inc_s  = (lock_cnt_r == 8'hFF) ? 8'hFF : lock_cnt_r + 8'd1;
        run_inc_s   = (err_run_r == 8'hFF) ? 8'hFF : err_run_r + 8'd1;
        err_count_s = (err_s && (err_count_r != 16'hFFFF)) ? err_count_r + 16'd1 : err_count_r;
        if (err_s) begin
            lock_cnt_s = 8'd0;
            err_run_s  = run_inc_s;
            locked_s   = locked_r && (run_inc_s < UNLOCK_N);
        end else if ((state_s == CTRL) || (state_s == PRE_V) || (state_s == PRE_D)) begin
            lock_cnt_s = lock_inc_s;
            err_run_s  = 8'd0;
            locked_s   = locked_r || (lock_inc_s >= LOCK_N);
        end else begin
            lock_cnt_s = lock_cnt_r;
            err_run_s  = 8'd0;
            locked_s   = locked_r;
        end
    end

    // Output and status registers
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            de_r <= 1'b0;  hsync_r <= 1'b0;  vsync_r <= 1'b0;  ctl_r <= 4'd0;
            rgb_r <= 24'd0;  terc4_r <= 12'd0;  di_valid_r <= 1'b0;  di_start_r <= 1'b0;
            guard_r <= 1'b0;  x_r <= 12'd0;  y_r <= 12'd0;  vs_pend_r <= 1'b0;
            locked_r <= 1'b0;  lock_cnt_r <= 8'd0;  err_run_r <= 8'd0;  err_count_r <= 16'd0;
        end else begin
            de_r <= de_s;  hsync_r <= hsync_s;  vsync_r <= vsync_s;  ctl_r <= ctl_s;
            rgb_r <= rgb_s;  terc4_r <= terc4_out_s;  di_valid_r <= di_valid_s;  di_start_r <= di_start_s;
            guard_r <= guard_s;  x_r <= x_s;  y_r <= y_s;  vs_pend_r <= vs_pend_s;
            locked_r <= locked_s;  lock_cnt_r <= lock_cnt_s;  err_run_r <= err_run_s;  err_count_r <= err_count_s;
        end
    end

    assign period_o    = state_r;
    assign de_o        = de_r;
    assign rgb_o       = rgb_r;
    assign hsync_o     = hsync_r;
    assign vsync_o     = vsync_r;
    assign ctl_o       = ctl_r;
    assign terc4_o     = terc4_r;
    assign di_valid_o  = di_valid_r;
    assign di_start_o  = di_start_r;
    assign guard_o     = guard_r;
    assign x_o         = x_r;
    assign y_o         = y_r;
    assign locked_o    = locked_r;
    assign err_count_o = err_count_r;

endmodule

// File: doc/hdmi_decoder.md
# hdmi_decoder

Three-channel TMDS/HDMI symbol decoder: the receive-side counterpart of the HDMI transmitter. It takes word-aligned 10-bit symbols per channel, one set per pixel clock, and tracks the HDMI period structure (control, preamble, guard band, video, data island). It recovers RGB pixels, DE, sync, CTL bits and TERC4 data-island nibbles, plus raster position, lock and error status. It sits behind the deserializer in loopback/diagnostic builds and feeds packet parsers and checkers in `clk_pixel`.

## Interface
Parameters:
- `LOCK_TOKENS`, 16: consecutive valid control-period cycles required to assert lock.
- `UNLOCK_ERRORS`, 8: consecutive invalid cycles that drop lock.
- `MAX_DI_PACKETS`, 18: maximum 32-cycle packets per data island.

Ports:
- `clk_pixel`  in  1: pixel clock; the only clock.
- `reset`  in  1: synchronous, active-high.
- `tmds_i`  in  [2:0][9:0]: aligned symbols, q[9] MSB; ch0 = blue/HSYNC,VSYNC; ch1 = green/CTL0,CTL1; ch2 = red/CTL2,CTL3.
- `rgb_o`  out  24: {ch2,ch1,ch0} decoded 8-bit data; valid when `de_o`.
- `de_o`  out  1: video period pixel.
- `hsync_o`, `vsync_o`  out  1 each: sync from ch0 control token or TERC4 bits [0]/[1].
- `ctl_o`  out  4: last decoded CTL3..CTL0.
- `terc4_o`  out  12: {ch2,ch1,ch0} nibbles; valid when `di_valid_o`.
- `di_valid_o`  out  1: data island payload cycle (guard bands excluded).
- `di_start_o`  out  1: first cycle of each 32-cycle packet.
- `guard_o`  out  1: current cycle is a guard band.
- `period_o`  out  3: FSM state (package enum).
- `x_o`, `y_o`  out  12 each: active pixel column and active line.
- `locked_o`  out  1: symbol stream is valid.
- `err_count_o`  out  16: saturating count of invalid cycles.

## Operation
- Per-channel decode: control tokens 1101010100→00, 0010101011→01, 0101010100→10, 1010101011→11 (c1c0).
  - Video data: d = q[9] ? ~q[7:0] : q[7:0]; out[0]=d[0]; out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
  - TERC4 uses the standard 16-entry table (0→1010011100 … F→1011000011).
  - Video guard band: ch0/ch2 1011001100, ch1 0100110011. Data-island guard band: ch1/ch2 0100110011; ch0 TERC4 {1,1,vsync,hsync}.
- FSM states: CTRL, PRE_V, PRE_D, VGB, VIDEO, DGB_LEAD, DATA, DGB_TRAIL.
  - CTRL: all channels carry control tokens. CTL=0001 → PRE_V; CTL=0101 → PRE_D, with preamble counter reset to 1.
  - PRE_x: counter increments while the same CTL pattern holds and saturates at 15. A pattern change returns the FSM to CTRL (or to the other preamble state) and restarts the count.
  - PRE_x with count ≥ 8, when the matching guard band appears on all channels → VGB / DGB_LEAD. Guard band with count < 8 → CTRL plus an error.
  - VGB / DGB_LEAD last exactly 2 cycles. A third guard cycle or a non-guard cycle during the guard band → error, then CTRL.
  - VIDEO: runs until control tokens appear on all three channels, then CTRL.
  - DATA: 32-cycle packet counter; `di_start_o` pulses at count 0. DI guard band on ch1 and ch2 → DGB_TRAIL. This is legal only at a packet boundary (count == 0 after ≥1 packet); otherwise it is an error.
  - Exceeding `MAX_DI_PACKETS`, or a non-TERC4 symbol in DATA, → error, then CTRL.
  - DGB_TRAIL: exactly 2 cycles, then CTRL.
- Invalid cycle: a symbol not legal in the current state. Each invalid cycle increments `err_count_o`, which saturates at FFFF.
- Lock:
  - `locked_o` sets after `LOCK_TOKENS` consecutive valid CTRL/PRE cycles.
  - It clears after `UNLOCK_ERRORS` consecutive invalid cycles.
  - The FSM runs regardless of lock.
- Raster:
  - `x_o` increments on each DE cycle and clears on the DE rising edge.
  - `y_o` increments on each DE falling edge and clears on the first DE rising edge after a `vsync_o` rising edge.
- In VIDEO: hsync, vsync and CTL hold their last values.
- In DATA: `hsync_o`/`vsync_o` follow ch0 TERC4 bits.

## Timing
- Latency: outputs are registered, 1 cycle after `tmds_i`. All outputs of a given symbol set are aligned in the same cycle.
- Reset: all outputs 0; `period_o` = CTRL; counters, `err_count_o` and lock cleared. Reset mid-island abandons the packet and emits no `di_valid_o`.
- Simultaneous error and lock threshold: the error wins, the lock count clears.
- `di_start_o` and the first `di_valid_o` coincide. The first DE cycle has `x_o` = 0.

## Structure
- Package `hdmi_decoder_pkg` holds:
  - `period_t` enum;
  - control-token, guard-band and TERC4 constants;
  - a `terc4_decode` function.
- Sub-module `tmds_symbol_decode` is purely combinational and instantiated ×3 (parameter CHANNEL). Its outputs are data8, is_ctrl, ctrl2, is_terc4, terc4, is_vgb, is_dgb.
- The FSM, counters and output registers live in `hdmi_decoder`.

## Test plan
- **Lock:** 20 cycles of token 1101010100 on all channels → `locked_o`=1 at cycle 17 output; `err_count_o`=0.
- **Video line:** 8 cycles CTL=0001 preamble, 2 video guard bands, then 640 symbols encoding R=0x12, G=0x34, B=0x56, then control → `de_o` for 640 cycles; `rgb_o`=123456; `x_o` runs 0..639; `y_o` increments once.
- **Data island:** 8 cycles CTL=0101, 2 DI guard bands, 64 TERC4 cycles with nibble 0xA, 2 guard bands → `di_start_o` at payload cycles 0 and 32; `terc4_o`=AAA; `period_o` returns to CTRL.
- **Short preamble:** 6 preamble cycles, then guard band → `err_count_o`+1; no `de_o`.
- **Misplaced trailing guard:** trailing guard band at packet count 17 → error, CTRL.
- **Reset and unlock:** reset mid-VIDEO → all outputs 0 next cycle. 8 random invalid symbols in CTRL → `locked_o` drops; `err_count_o`=8.
